pixel_stream_monitor: RTL and testbench

- Sink for the display pixel stream (`sx`/`sy`/`de`/RGB), i.e. the receiving end of the interface our pattern and game generators drive.
- Locks onto the raster and checks every active pixel arrives in strict raster order.
- Per frame, produces a checksum, a frame counter and an error counter.
- Sits beside the simulation display sink and is used for self-checking benches and on-chip debug of video generators.

---
 rtl/video_pkg.sv | 39 +++
 rtl/raster_counter.sv | 65 ++++++
 rtl/pixel_stream_monitor.sv | 183 ++++++++++++++++++
 tb/tb_pixel_stream_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and defaults for the display pixel stream:
//                raster size defaults, the pixel bundle carried on the
//                sx/sy/de/RGB interface, the monitor state encoding and a
//                colour-sum helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int CW_DEF    = 10;

  // One sample of the pixel stream as seen on the wire.
  typedef struct packed {
    logic [CW_DEF-1:0] sx;
    logic [CW_DEF-1:0] sy;
    logic              de;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
  } pixel_t;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } mon_state_t;

  // r+g+b of one pixel; 10 bits hold the worst case 3*255.
  function automatic logic [9:0] rgb_sum(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    return {2'b00, r} + {2'b00, g} + {2'b00, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : Expected-coordinate (ex, ey) counter walking the active
//                raster in row-major order.
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                i_clr        - return to the origin
//                i_adv        - advance one pixel (with i_clr: origin was
//                               just consumed, so land on (1,0))
//                o_ex, o_ey   - expected coordinate of the next pixel
//                o_last       - (ex,ey) is the final pixel of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_counter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int CW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [CW-1:0] o_ex,
  output logic [CW-1:0] o_ey,
  output logic          o_last
);

  localparam logic [CW-1:0] C_LAST_X = CW'(H_RES - 1);
  localparam logic [CW-1:0] C_LAST_Y = CW'(V_RES - 1);

  logic [CW-1:0] ex_q, ex_d;
  logic [CW-1:0] ey_q, ey_d;

  always_comb begin
    ex_d = ex_q;
    ey_d = ey_q;
    if (i_clr) begin
      ex_d = i_adv ? CW'(1) : '0;
      ey_d = '0;
    end else if (i_adv) begin
      if (ex_q == C_LAST_X) begin
        ex_d = '0;
        ey_d = (ey_q == C_LAST_Y) ? '0 : ey_q + CW'(1);
      end else begin
        ex_d = ex_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
      ey_q <= '0;
    end else begin
      ex_q <= ex_d;
      ey_q <= ey_d;
    end
  end

  assign o_ex   = ex_q;
  assign o_ey   = ey_q;
  assign o_last = (ex_q == C_LAST_X) && (ey_q == C_LAST_Y);

endmodule
`default_nettype wire

// File: rtl/pixel_stream_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_stream_monitor
//  Description : Sink for the display pixel stream. Locks onto the raster,
//                checks that active pixels arrive in strict raster order and
//                reports a per-frame r+g+b checksum, frame count and
//                sequence-error count.
//  Ports       : clk_pix, sim_rst          - pixel clock, async high reset
//                sdl_sx/sy/de/r/g/b        - incoming pixel stream
//                locked                    - tracking a frame
//                frame_done, frame_sum     - clean-frame pulse and checksum
//                frame_cnt                 - completed frames (wrapping)
//                err, err_cnt              - sequence-error pulse and count
//                                            (saturating)
//  Pipeline    : inputs registered at edge T, FSM/accumulator update at
//                T+1, outputs registered at T+2.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_monitor
  import video_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int CW    = CW_DEF      // must equal CW_DEF (pixel_t width)
) (
  input  logic          clk_pix,
  input  logic          sim_rst,
  input  logic [CW-1:0] sdl_sx,
  input  logic [CW-1:0] sdl_sy,
  input  logic          sdl_de,
  input  logic [7:0]    sdl_r,
  input  logic [7:0]    sdl_g,
  input  logic [7:0]    sdl_b,
  output logic          locked,
  output logic          frame_done,
  output logic [31:0]   frame_sum,
  output logic [15:0]   frame_cnt,
  output logic          err,
  output logic [15:0]   err_cnt
);

  // Stage 1: input register
  pixel_t     in_q, in_d;

  // Stage 2: FSM, accumulator and completion/error events
  mon_state_t state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic        done_ev_q, done_ev_d;
  logic        err_ev_q, err_ev_d;
  logic [31:0] sum_ev_q, sum_ev_d;

  // Output registers
  logic        locked_q, locked_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] frame_sum_q, frame_sum_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic          rc_clr, rc_adv, rc_last;
  logic [CW-1:0] rc_ex, rc_ey;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .CW    (CW)
  ) u_raster_counter (
    .clk    (clk_pix),
    .rst    (sim_rst),
    .i_clr  (rc_clr),
    .i_adv  (rc_adv),
    .o_ex   (rc_ex),
    .o_ey   (rc_ey),
    .o_last (rc_last)
  );

  logic [31:0] px_sum;
  logic        px_origin;
  logic        px_match;

  always_comb begin
    in_d.sx = sdl_sx;
    in_d.sy = sdl_sy;
    in_d.de = sdl_de;
    in_d.r  = sdl_r;
    in_d.g  = sdl_g;
    in_d.b  = sdl_b;

    px_sum    = {22'd0, rgb_sum(in_q.r, in_q.g, in_q.b)};
    px_origin = (in_q.sx == '0) && (in_q.sy == '0);
    // ex/ey never leave the active area, so out-of-range coordinates can
    // never match and fall into the error path automatically.
    px_match  = (in_q.sx == rc_ex) && (in_q.sy == rc_ey);

    state_d   = state_q;
    acc_d     = acc_q;
    done_ev_d = 1'b0;
    err_ev_d  = 1'b0;
    sum_ev_d  = sum_ev_q;
    rc_clr    = 1'b0;
    rc_adv    = 1'b0;

    if (in_q.de) begin
      if (state_q == SEARCH) begin
        if (px_origin) begin
          acc_d   = px_sum;
          rc_clr  = 1'b1;
          rc_adv  = 1'b1;
          state_d = LOCKED;
        end
      end else if (px_match) begin
        if (rc_last) begin
          sum_ev_d  = acc_q + px_sum;
          done_ev_d = 1'b1;
          acc_d     = '0;
          rc_clr    = 1'b1;
        end else begin
          acc_d  = acc_q + px_sum;
          rc_adv = 1'b1;
        end
      end else begin
        err_ev_d = 1'b1;
        if (px_origin) begin
          // The offending pixel is itself a valid frame start: relock on it.
          acc_d  = px_sum;
          rc_clr = 1'b1;
          rc_adv = 1'b1;
        end else begin
          acc_d   = '0;
          rc_clr  = 1'b1;
          state_d = SEARCH;
        end
      end
    end

    locked_d     = (state_q == LOCKED);
    frame_done_d = done_ev_q;
    err_d        = err_ev_q;
    frame_sum_d  = done_ev_q ? sum_ev_q : frame_sum_q;
    frame_cnt_d  = frame_cnt_q + {15'd0, done_ev_q};
    err_cnt_d    = (err_ev_q && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1
                                                         : err_cnt_q;
  end

  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      in_q         <= '0;
      state_q      <= SEARCH;
      acc_q        <= '0;
      done_ev_q    <= 1'b0;
      err_ev_q     <= 1'b0;
      sum_ev_q     <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_sum_q  <= '0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      in_q         <= in_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      done_ev_q    <= done_ev_d;
      err_ev_q     <= err_ev_d;
      sum_ev_q     <= sum_ev_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      frame_sum_q  <= frame_sum_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign frame_sum  = frame_sum_q;
  assign frame_cnt  = frame_cnt_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_stream_monitor
//  Description : Directed self-checking bench for pixel_stream_monitor on a
//                4x3 raster. Pixel (1,2,3) frames sum to 12*6 = 72.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_monitor;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int CW = 10;

  logic          clk_pix = 1'b0;
  logic          sim_rst = 1'b1;
  logic [CW-1:0] sdl_sx  = '0;
  logic [CW-1:0] sdl_sy  = '0;
  logic          sdl_de  = 1'b0;
  logic [7:0]    sdl_r   = '0;
  logic [7:0]    sdl_g   = '0;
  logic [7:0]    sdl_b   = '0;
  logic          locked;
  logic          frame_done;
  logic [31:0]   frame_sum;
  logic [15:0]   frame_cnt;
  logic          err;
  logic [15:0]   err_cnt;

  pixel_stream_monitor #(
    .H_RES (H),
    .V_RES (V),
    .CW    (CW)
  ) dut (
    .clk_pix    (clk_pix),
    .sim_rst    (sim_rst),
    .sdl_sx     (sdl_sx),
    .sdl_sy     (sdl_sy),
    .sdl_de     (sdl_de),
    .sdl_r      (sdl_r),
    .sdl_g      (sdl_g),
    .sdl_b      (sdl_b),
    .locked     (locked),
    .frame_done (frame_done),
    .frame_sum  (frame_sum),
    .frame_cnt  (frame_cnt),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int done_base;
  int err_base;

  // Pulse counters, sampled 1 time unit after each rising edge.
  always @(posedge clk_pix) begin
    #1;
    if (frame_done === 1'b1) done_seen++;
    if (err === 1'b1) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a falling edge and return at the next falling edge.
  task automatic step(input int x, input int y, input logic de,
                      input logic [7:0] rr, input logic [7:0] gg,
                      input logic [7:0] bb);
    sdl_sx = CW'(x);
    sdl_sy = CW'(y);
    sdl_de = de;
    sdl_r  = rr;
    sdl_g  = gg;
    sdl_b  = bb;
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  // Blanking cycles with junk coordinates and colour.
  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0,
           8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic frame(input logic [7:0] rr, input logic [7:0] gg,
                       input logic [7:0] bb);
    for (int k = 0; k < H * V; k++) step(k % H, k / H, 1'b1, rr, gg, bb);
  endtask

  initial begin
    // ---- reset state ----
    @(negedge clk_pix);
    @(negedge clk_pix);
    check("rst_locked",     32'(locked),     32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_sum",  frame_sum,       32'd0);
    check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_err_cnt",    32'(err_cnt),    32'd0);
    sim_rst = 1'b0;

    // ---- stream entering at (2,0): silently discarded ----
    done_base = done_seen; err_base = err_seen;
    for (int i = 2; i < H * V; i++) step(i % H, i / H, 1'b1, 8'd1, 8'd2, 8'd3);
    idle(2);
    check("mid_start_locked", 32'(locked),          32'd0);
    check("mid_start_err",    32'(err_seen - err_base),   32'd0);
    check("mid_start_done",   32'(done_seen - done_base), 32'd0);

    // ---- two back-to-back clean frames ----
    done_base = done_seen;
    frame(8'd1, 8'd2, 8'd3);
    for (int i = 0; i < H * V; i++) begin
      step(i % H, i / H, 1'b1, 8'd1, 8'd2, 8'd3);
      if (i == 0) check("f1_done_early", 32'(frame_done), 32'd0);
      if (i == 1) begin
        check("f1_done",  32'(frame_done), 32'd1);
        check("f1_sum",   frame_sum,       32'h48);
        check("f1_cnt",   32'(frame_cnt),  32'd1);
      end
    end
    idle(1);
    check("f2_done_early", 32'(frame_done), 32'd0);
    idle(1);
    check("f2_done",    32'(frame_done), 32'd1);
    check("f2_sum",     frame_sum,       32'h48);
    check("f2_cnt",     32'(frame_cnt),  32'd2);
    check("f2_err_cnt", 32'(err_cnt),    32'd0);
    check("f2_locked",  32'(locked),     32'd1);
    check("f2_pulses",  32'(done_seen - done_base), 32'd2);

    // ---- frame with blanking gaps of 1 and 5 cycles ----
    done_base = done_seen; err_base = err_seen;
    for (int i = 0; i < H * V; i++) begin
      step(i % H, i / H, 1'b1, 8'd1, 8'd2, 8'd3);
      if (i < H * V - 1) idle((i % 2 == 0) ? 1 : 5);
    end
    idle(2);
    check("gap_sum",   frame_sum,      32'h48);
    check("gap_cnt",   32'(frame_cnt), 32'd3);
    check("gap_err",   32'(err_seen - err_base),   32'd0);
    check("gap_done",  32'(done_seen - done_base), 32'd1);

    // ---- (2,1) replaced by (3,1) ----
    done_base = done_seen; err_base = err_seen;
    for (int i = 0; i < H * V; i++) begin
      if (i == 6) step(3, 1, 1'b1, 8'd1, 8'd2, 8'd3);
      else        step(i % H, i / H, 1'b1, 8'd1, 8'd2, 8'd3);
    end
    idle(2);
    check("skip_err",     32'(err_seen - err_base),   32'd1);
    check("skip_err_cnt", 32'(err_cnt),               32'd1);
    check("skip_locked",  32'(locked),                32'd0);
    check("skip_done",    32'(done_seen - done_base), 32'd0);
    check("skip_cnt",     32'(frame_cnt),             32'd3);
    frame(8'd1, 8'd2, 8'd3);
    idle(2);
    check("skip_next_cnt", 32'(frame_cnt), 32'd4);
    check("skip_next_sum", frame_sum,      32'h48);

    // ---- abort after (1,1), restart at (0,0) ----
    done_base = done_seen; err_base = err_seen;
    for (int i = 0; i < 6; i++) step(i % H, i / H, 1'b1, 8'd1, 8'd2, 8'd3);
    step(0, 0, 1'b1, 8'd1, 8'd2, 8'd3);
    step(1, 0, 1'b1, 8'd1, 8'd2, 8'd3);
    check("relock_err_early", 32'(err), 32'd0);
    step(2, 0, 1'b1, 8'd1, 8'd2, 8'd3);
    check("relock_err",    32'(err),    32'd1);
    check("relock_locked", 32'(locked), 32'd1);
    for (int i = 3; i < H * V; i++) step(i % H, i / H, 1'b1, 8'd1, 8'd2, 8'd3);
    idle(2);
    check("relock_sum",     frame_sum,      32'h48);
    check("relock_cnt",     32'(frame_cnt), 32'd5);
    check("relock_done",    32'(done_seen - done_base), 32'd1);
    check("relock_err_cnt", 32'(err_cnt),   32'd2);
    check("relock_pulses",  32'(err_seen - err_base),   32'd1);

    // ---- full-scale colour: 12 * 765 = 9180 ----
    frame(8'hFF, 8'hFF, 8'hFF);
    idle(2);
    check("white_sum", frame_sum,      32'd9180);
    check("white_cnt", 32'(frame_cnt), 32'd6);

    // ---- asynchronous reset mid-frame ----
    for (int i = 0; i < 5; i++) step(i % H, i / H, 1'b1, 8'd1, 8'd2, 8'd3);
    check("pre_rst_locked", 32'(locked), 32'd1);
    @(posedge clk_pix);
    #2 sim_rst = 1'b1;
    #1;
    check("arst_locked",     32'(locked),     32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_frame_sum",  frame_sum,       32'd0);
    check("arst_frame_cnt",  32'(frame_cnt),  32'd0);
    check("arst_err",        32'(err),        32'd0);
    check("arst_err_cnt",    32'(err_cnt),    32'd0);
    @(negedge clk_pix);
    sim_rst = 1'b0;
    for (int i = 1; i < H; i++) step(i, 0, 1'b1, 8'd1, 8'd2, 8'd3);
    idle(2);
    check("post_rst_locked", 32'(locked), 32'd0);
    frame(8'd1, 8'd2, 8'd3);
    idle(2);
    check("post_rst_relock", 32'(locked),    32'd1);
    check("post_rst_cnt",    32'(frame_cnt), 32'd1);
    check("post_rst_sum",    frame_sum,      32'h48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
